bcd_serial_adder: RTL and testbench

- Parametrised, digit-serial packed-BCD adder/subtractor for N-digit operands.
- Processes one BCD digit per clock, least-significant first, using a single-digit binary add followed by decimal correction: a digit sum above 9 becomes sum-10 with carry 1.
- Start/busy/done handshake; invalid-digit detection. Serves as the multi-digit arithmetic core for the calculator/display datapath.

---
 rtl/bcd_serial_adder_if.sv | 27 ++
 rtl/bcd_serial_adder.sv | 132 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Bus bundle for the digit-serial BCD adder: operands, handshake and registered results.
// The master launches operations and the slave (the adder) returns results and status.
interface bcd_serial_adder_if #(
    parameter int NDIGITS = 4
);
    logic                   start;
    logic                   sub;
    logic                   cin;
    logic [4*NDIGITS-1:0]   a;
    logic [4*NDIGITS-1:0]   b;
    logic [4*NDIGITS-1:0]   sum;
    logic                   cout;
    logic                   invalid;
    logic                   busy;
    logic                   done;
    logic [1:0]             state;

    modport master (
        output start, sub, cin, a, b,
        input  sum, cout, invalid, busy, done, state
    );

    modport slave (
        input  start, sub, cin, a, b,
        output sum, cout, invalid, busy, done, state
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// binary digit add with decimal correction; subtraction uses nine's complement plus one.
module bcd_serial_adder #(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_adder_if.slave    bus
);
    localparam int W  = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE); start while
    // busy is dropped, not queued. done pulses for one cycle when sum/cout/invalid are valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, work_q, sum_q;
    logic            sub_q, carry_q, cout_q, invalid_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    logic            bad_in;
    logic            last;
    logic [3:0]      a_dig, b_dig, bd, digit;
    logic [4:0]      s, s_adj;
    logic            carry_d;
    logic [W-1:0]    work_d;

    // Any nibble above 9 in either operand makes the request invalid.
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    assign accept = bus.start && (state_q != RUN);
    assign last   = (cnt_q == CW'(NDIGITS - 1));

    // Operands shift right each RUN cycle, so the active digit is always in [3:0].
    always_comb begin
        a_dig   = a_q[3:0];
        b_dig   = b_q[3:0];
        bd      = sub_q ? (4'd9 - b_dig) : b_dig;
        s       = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry_q};
        s_adj   = s - 5'd10;
        carry_d = 1'b0;
        digit   = s[3:0];
        if (s > 5'd9) begin
            carry_d = 1'b1;
            digit   = s_adj[3:0];
        end
        work_d = (work_q >> 4) | (W'(digit) << (W - 4));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = bad_in ? DONE : RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (accept) state_d = bad_in ? DONE : RUN;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            sum_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
            work_q  <= '0;
            if (bad_in) begin
                sum_q     <= '0;
                cout_q    <= 1'b0;
                invalid_q <= 1'b1;
            end else begin
                invalid_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            carry_q <= carry_d;
            cnt_q   <= cnt_q + 1'b1;
            work_q  <= work_d;
            if (last) begin
                sum_q  <= work_d;
                cout_q <= carry_d;
            end
        end
    end

    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.invalid = invalid_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.state   = state_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (NDIGITS=4): hand-computed BCD sums, latency,
// busy duration, invalid-digit handling, back-to-back starts and mid-run reset.
module tb_bcd_serial_adder;
    localparam int ND = 4;
    localparam int W  = 4 * ND;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    logic [W-1:0] exp_q[$];

    bcd_serial_adder_if #(.NDIGITS(ND)) bus ();

    bcd_serial_adder #(.NDIGITS(ND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a request in the current cycle; lat counts edges after the accept edge
    // until done is visible (NDIGITS for valid operands, 0 for invalid ones).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic cv,
                          input logic [W-1:0] esum, input logic ecout,
                          input logic einv, input int elat, input bit hold_start);
        logic [W-1:0] prev;
        logic [W-1:0] exp_sum;
        bit           held_ok;
        int           lat;
        int           busy_cnt;
        prev     = bus.sum;
        held_ok  = 1'b1;
        bus.a    = av;
        bus.b    = bv;
        bus.sub  = sv;
        bus.cin  = cv;
        bus.start = 1'b1;
        exp_q.push_back(esum);
        @(posedge clk);
        #1;
        if (!hold_start) bus.start = 1'b0;
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.sub = 1'($urandom_range(0, 1));
        bus.cin = 1'($urandom_range(0, 1));
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.sum !== prev) held_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        exp_sum = exp_q.pop_front();
        check("done_seen", {31'd0, bus.done}, 32'd1);
        check("latency", lat, elat);
        check("busy_cycles", busy_cnt, elat);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("sum", {16'd0, bus.sum}, {16'd0, exp_sum});
        check("cout", {31'd0, bus.cout}, {31'd0, ecout});
        check("invalid", {31'd0, bus.invalid}, {31'd0, einv});
        check("sum_held", {31'd0, held_ok}, 32'd1);
    endtask

    initial begin
        bit no_done;
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        idle(3);
        check("rst_sum", {16'd0, bus.sum}, 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_invalid", {31'd0, bus.invalid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        idle(2);

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 4, 1'b0);
        idle(2);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
        idle(1);
        run_op(16'h0999, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 4, 1'b0);
        idle(1);
        run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 4, 1'b0);
        idle(1);
        // Subtraction with cin=1 must ignore the carry-in.
        run_op(16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0, 4, 1'b0);
        idle(1);
        run_op(16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 4, 1'b0);
        idle(1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
        idle(1);

        run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 4, 1'b0);
        idle(1);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        idle(1);
        run_op(16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4, 1'b0);
        idle(1);

        // start held through RUN, then back-to-back launch from the DONE cycle.
        run_op(16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0, 4, 1'b1);
        run_op(16'h8000, 16'h3000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 4, 1'b0);
        run_op(16'h0007, 16'h0009, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0, 4, 1'b0);
        idle(2);

        // Reset asserted during the second RUN cycle abandons the operation.
        bus.a     = 16'h5555;
        bus.b     = 16'h1111;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_sum", {16'd0, bus.sum}, 32'd0);
        check("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        no_done = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) no_done = 1'b0;
        end
        check("mid_rst_quiet", {31'd0, no_done}, 32'd1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 4, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
